// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshake-driven pipeline stage register.
//
// Holds an opaque packed stage payload in a two-entry (main + skid) buffer
// with valid/ready flow control, synchronous flush and a fixed bubble value
// presented whenever no valid entry is held.
//
// Ports:
//   CLK        rising-edge clock
//   nRST       asynchronous active-low reset
//   in_valid   upstream offers in_data
//   in_ready   block can accept (function of registered state only)
//   in_data    packed payload from the upstream stage
//   flush      synchronous discard of all held entries
//   out_valid  out_data holds a valid entry
//   out_ready  downstream consumes out_data (low = stall)
//   out_data   oldest held entry, or BUBBLE_VAL when empty
//   count      number of held entries (0..2)
//
// Optional build macro PIPE_STAGE_PERF_EN adds:
//   clr_cnt    synchronous clear of both counters
//   stall_cnt  saturating count of cycles with out_valid & !out_ready
//   squash_cnt saturating count of flush edges that discarded entries
module pipe_stage_reg #(
   parameter int unsigned       DATA_W     = 128,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
`ifdef PIPE_STAGE_PERF_EN
   ,
   parameter int unsigned       CNT_W      = 16
`endif
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        count
`ifdef PIPE_STAGE_PERF_EN
   ,
   input  logic              clr_cnt,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  squash_cnt
`endif
);

   typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;

   logic acc;
   logic drn;

   // Outputs derive from registered state only, so in_ready never combines
   // with out_ready and the stall path between stages stays cut.
   assign out_data  = main_q;
   assign out_valid = (state_q != StEmpty);
   assign in_ready  = (state_q != StFull);

   assign acc = in_valid & in_ready;
   assign drn = out_valid & out_ready;

   always_comb begin
      count = 2'd0;
      case (state_q)
         StOne:   count = 2'd1;
         StFull:  count = 2'd2;
         default: count = 2'd0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         // Flush wins over acc and drn; a same-cycle drn is still consumed
         // downstream, we simply drop our copy.
         state_d = StEmpty;
         main_d  = BUBBLE_VAL;
         skid_d  = BUBBLE_VAL;
      end else begin
         case (state_q)
            StEmpty: begin
               if (acc) begin
                  main_d  = in_data;
                  state_d = StOne;
               end
            end
            StOne: begin
               case ({acc, drn})
                  2'b10: begin
                     skid_d  = in_data;
                     state_d = StFull;
                  end
                  2'b11: begin
                     // Pass-through: refill main as it drains.
                     main_d = in_data;
                  end
                  2'b01: begin
                     main_d  = BUBBLE_VAL;
                     state_d = StEmpty;
                  end
                  default: ;
               endcase
            end
            StFull: begin
               if (drn) begin
                  main_d  = skid_q;
                  skid_d  = BUBBLE_VAL;
                  state_d = StOne;
               end
            end
            default: begin
               state_d = StEmpty;
               main_d  = BUBBLE_VAL;
               skid_d  = BUBBLE_VAL;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= StEmpty;
         main_q  <= BUBBLE_VAL;
         skid_q  <= BUBBLE_VAL;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

   assign stall_cnt  = stall_cnt_q;
   assign squash_cnt = squash_cnt_q;

   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      squash_cnt_d = squash_cnt_q;
      if (clr_cnt) begin
         stall_cnt_d  = '0;
         squash_cnt_d = '0;
      end else begin
         // Both counters stick at all-ones instead of wrapping.
         if (out_valid && !out_ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
         if (flush && (state_q != StEmpty) && !(&squash_cnt_q)) begin
            squash_cnt_d = squash_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt_q  <= '0;
         squash_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         squash_cnt_q <= squash_cnt_d;
      end
   end
`endif

endmodule
